skew_monitor: RTL
=================

Name: skew_monitor

Overview:
- Synthesizable, run-time successor to the bench-only TX/RX skew check.
- Measures, in clkIn ticks, the delay from each reference-strobe rising edge to the next rising edge on each of NUM_CH channel strobes.
- Strobes are fabric-sampled copies of PHY or fabric clocks/data.
- Checks each delay against a programmable [min,max] window, accumulates per-channel min/max/error statistics over a run of N measurements, and reports pass/fail to the top level and the mmcm bring-up logic.

Parameters:
- NUM_CH, 2, number of monitored channel strobes.
- CNT_W, 8, skew counter width in ticks; all-ones = timeout.
- SYNC_STAGES, 2, synchronizer depth, applied identically to refIn and every channel.
- ERR_W, 8, per-channel saturating error counter width.

Ports:
- clkIn  in  1  measurement clock; all logic in this domain.
- rstBIn  in  1  asynchronous active-low reset.
- startIn  in  1  one-cycle pulse; begins a run; ignored while busyOut=1.
- numMeasIn  in  16  measurements per run; sampled on start; 0 treated as 1.
- minSkewIn  in  CNT_W  lower window bound (inclusive); sampled on start.
- maxSkewIn  in  CNT_W  upper window bound (inclusive); sampled on start.
- refIn  in  1  asynchronous reference strobe.
- chanIn  in  NUM_CH  asynchronous channel strobes.
- busyOut  out  1  high from the cycle after start until doneOut.
- doneOut  out  1  one-cycle pulse at end of run.
- passOut  out  1  1 iff every errCnt is 0 at done; held until next start.
- skewOut  out  NUM_CH*CNT_W  last captured skew per channel.
- minObsOut  out  NUM_CH*CNT_W  smallest skew seen in run.
- maxObsOut  out  NUM_CH*CNT_W  largest skew seen in run.
- errCntOut  out  NUM_CH*ERR_W  out-of-window plus timeout count; saturates at all-ones.

Behaviour:
- Reset (async, rstBIn=0):
  - All outputs 0; FSM IDLE; synchronizers cleared.
  - minObs resets to 0 here and is set to all-ones on start.
- Sync and edge detect:
  - Each input passes through SYNC_STAGES flops plus a prev flop; edge = sync & ~prev.
  - Equal latency on all paths preserves relative skew.
- FSM IDLE -> ARM on startIn:
  - Latch numMeas/min/max.
  - Clear errCnt, maxObs and measCnt; minObs = all-ones; passOut = 0.
- ARM -> WAIT_REF, one cycle.
- WAIT_REF -> MEAS on ref edge:
  - Per-channel counter loads 0 in the edge cycle.
  - A channel edge in that same cycle captures skew 0.
  - Channel edges seen in WAIT_REF are ignored.
- MEAS:
  - Counters increment each cycle.
  - Each channel captures the first edge only, storing the counter value into skewOut and updating min/max.
  - Capture is an error if skew < min or > max.
  - Further ref edges and further channel edges are ignored until the window ends.
  - The window ends when all channels have captured, or the counter reaches all-ones.
  - On timeout, uncaptured channels record skewOut = all-ones and err++; min/max are not updated.
  - At window end, measCnt++. If measCnt == numMeas, go to DONE; otherwise go to WAIT_REF.
- DONE:
  - doneOut = 1 for one cycle; passOut registered; busyOut = 0.
  - Next cycle IDLE. startIn in the DONE cycle is ignored.
- Error counter saturation: at all-ones further errors do not wrap.
- minSkewIn > maxSkewIn: every capture is an error; no special casing.
- Reset mid-run: immediate return to IDLE with all outputs cleared.

Optional Feature:
- Macro SKEW_MON_IRQ_EN.
- When defined: adds output irqOut (1 bit), a sticky flag set in the cycle after the first error in a run (one cycle after the error's capture/timeout cycle). Cleared only by startIn or reset.
- When undefined: the port is absent, and there is no logic or behavioural change elsewhere.

Decomposition:
- Package skew_mon_pkg:
  - State enum (IDLE, ARM, WAIT_REF, MEAS, DONE).
  - Localparam helper for the all-ones timeout value.
  - Function inWindow(skew, min, max).
- Sub-module skew_mon_chan, generated NUM_CH times:
  - Synchronizer, edge detect, counter, capture, min/max/err stats.
- Top level keeps the FSM, ref-path sync and measCnt.

Test Plan:
- Single channel in window: chan[0] edge 3 ticks after ref, min=2, max=4, numMeas=4 -> skewOut=3, minObs=maxObs=3, errCnt=0, passOut=1, doneOut after 4th window.
- Out of window: chan[1] delay 6, min=2, max=4, numMeas=5 -> errCnt[1]=5, passOut=0, skewOut[1]=6.
- Timeout: chan[0] held low, CNT_W=8 -> skewOut[0]=255, errCnt[0]=1 per window, doneOut still asserts.
- Simultaneous edges and saturation:
  - ref and chan in the same cycle -> skew 0.
  - ERR_W=4 with 20 errors -> errCnt=15.
- Control hazards:
  - startIn while busy ignored.
  - numMeasIn=0 -> exactly one window.
  - rstBIn low in MEAS -> all outputs 0 asynchronously, FSM IDLE.
- IRQ (SKEW_MON_IRQ_EN): first error sets irqOut one cycle after the error's capture/timeout cycle, and it stays set through done; the next startIn clears it.

Source files
------------

// File: rtl/skew_mon_pkg.sv
// skew_monitor shared types: FSM states, all-ones helper and window check.
// Optional IRQ output is enabled by defining SKEW_MON_IRQ_EN.
package skew_mon_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT_REF,
    MEAS,
    DONE
  } state_e;

  localparam int unsigned MAX_W = 32;

  function automatic logic [MAX_W-1:0] allOnes(input int unsigned w);
    return (w >= MAX_W) ? '1 : ~({MAX_W{1'b1}} << w);
  endfunction

  function automatic logic inWindow(
    input logic [MAX_W-1:0] skew,
    input logic [MAX_W-1:0] lo,
    input logic [MAX_W-1:0] hi
  );
    return (skew >= lo) && (skew <= hi);
  endfunction

endpackage

// File: rtl/skew_mon_chan.sv
// One monitored strobe: synchronizer, edge detect, skew counter,
// first-edge capture and per-run min/max/error statistics.
module skew_mon_chan
  import skew_mon_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ERR_W       = 8
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             strobe_i,
  input  logic             clear_i,
  input  logic             ref_start_i,
  input  logic             meas_i,
  input  logic [CNT_W-1:0] min_i,
  input  logic [CNT_W-1:0] max_i,
  output logic             done_o,
  output logic             err_ev_o,
  output logic [CNT_W-1:0] skew_o,
  output logic [CNT_W-1:0] min_o,
  output logic [CNT_W-1:0] max_o,
  output logic [ERR_W-1:0] err_o
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(allOnes(CNT_W));

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   capd_q, capd_d;
  logic [CNT_W-1:0]       skew_q, skew_d;
  logic [CNT_W-1:0]       min_q, min_d;
  logic [CNT_W-1:0]       max_q, max_d;
  logic [ERR_W-1:0]       err_q, err_d;
  logic                   edge_w, cap_w, tmo_w, in_win, err_ev;
  logic [CNT_W-1:0]       cap_val;

  always_comb begin
    edge_w  = sync_q[SYNC_STAGES-1] & ~prev_q;
    cap_w   = edge_w & (ref_start_i | (meas_i & ~capd_q));
    cap_val = ref_start_i ? '0 : cnt_q;
    tmo_w   = meas_i & ~capd_q & ~edge_w & (cnt_q == TMO);
    in_win  = inWindow(MAX_W'(cap_val), MAX_W'(min_i), MAX_W'(max_i));
    err_ev  = (cap_w & ~in_win) | tmo_w;

    cnt_d = cnt_q;
    if (ref_start_i)
      cnt_d = CNT_W'(1);
    else if (meas_i)
      cnt_d = cnt_q + 1'b1;

    capd_d = capd_q;
    if (ref_start_i)
      capd_d = cap_w;
    else if (cap_w)
      capd_d = 1'b1;

    skew_d = skew_q;
    min_d  = min_q;
    max_d  = max_q;
    err_d  = err_q;
    if (clear_i) begin
      err_d = '0;
      max_d = '0;
      min_d = TMO;
    end else begin
      if (cap_w) begin
        skew_d = cap_val;
        if (cap_val < min_q) min_d = cap_val;
        if (cap_val > max_q) max_d = cap_val;
      end
      // timeout overrides the skew but leaves min/max untouched
      if (tmo_w)
        skew_d = TMO;
      if (err_ev && (err_q != '1))
        err_d = err_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      cnt_q  <= '0;
      capd_q <= 1'b0;
      skew_q <= '0;
      min_q  <= '0;
      max_q  <= '0;
      err_q  <= '0;
    end else begin
      sync_q[0] <= strobe_i;
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      prev_q <= sync_q[SYNC_STAGES-1];
      cnt_q  <= cnt_d;
      capd_q <= capd_d;
      skew_q <= skew_d;
      min_q  <= min_d;
      max_q  <= max_d;
      err_q  <= err_d;
    end
  end

  assign done_o   = capd_q | cap_w | tmo_w;
  assign err_ev_o = err_ev;
  assign skew_o   = skew_q;
  assign min_o    = min_q;
  assign max_o    = max_q;
  assign err_o    = err_q;

endmodule

// File: rtl/skew_monitor.sv
// Ref-to-channel strobe skew monitor: run FSM, ref sync and window count.
// Define SKEW_MON_IRQ_EN to add the sticky irqOut error flag.
module skew_monitor
  import skew_mon_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ERR_W       = 8
) (
  input  logic                    clkIn,
  input  logic                    rstBIn,
  input  logic                    startIn,
  input  logic [15:0]             numMeasIn,
  input  logic [CNT_W-1:0]        minSkewIn,
  input  logic [CNT_W-1:0]        maxSkewIn,
  input  logic                    refIn,
  input  logic [NUM_CH-1:0]       chanIn,
  output logic                    busyOut,
  output logic                    doneOut,
  output logic                    passOut,
  output logic [NUM_CH*CNT_W-1:0] skewOut,
  output logic [NUM_CH*CNT_W-1:0] minObsOut,
  output logic [NUM_CH*CNT_W-1:0] maxObsOut,
  output logic [NUM_CH*ERR_W-1:0] errCntOut
`ifdef SKEW_MON_IRQ_EN
  ,
  output logic                    irqOut
`endif
);

  state_e                 state_q, state_d;
  logic [15:0]            meas_cnt_q, meas_cnt_d;
  logic [15:0]            num_q, num_d;
  logic [CNT_W-1:0]       min_q, min_d;
  logic [CNT_W-1:0]       max_q, max_d;
  logic                   pass_q, pass_d;
  logic [SYNC_STAGES-1:0] ref_sync_q;
  logic                   ref_prev_q;
  logic                   ref_edge, start_ok, ref_start, meas, win_end;
  logic [NUM_CH-1:0]      chan_done, chan_err_ev, chan_clean;

  assign ref_edge  = ref_sync_q[SYNC_STAGES-1] & ~ref_prev_q;
  assign start_ok  = (state_q == IDLE) & startIn;
  assign ref_start = (state_q == WAIT_REF) & ref_edge;
  assign meas      = (state_q == MEAS);
  assign win_end   = meas & (&chan_done);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [ERR_W-1:0] err_w;

    skew_mon_chan #(
      .CNT_W      (CNT_W),
      .SYNC_STAGES(SYNC_STAGES),
      .ERR_W      (ERR_W)
    ) u_chan (
      .clk_i      (clkIn),
      .rst_n_i    (rstBIn),
      .strobe_i   (chanIn[g]),
      .clear_i    (start_ok),
      .ref_start_i(ref_start),
      .meas_i     (meas),
      .min_i      (min_q),
      .max_i      (max_q),
      .done_o     (chan_done[g]),
      .err_ev_o   (chan_err_ev[g]),
      .skew_o     (skewOut[g*CNT_W +: CNT_W]),
      .min_o      (minObsOut[g*CNT_W +: CNT_W]),
      .max_o      (maxObsOut[g*CNT_W +: CNT_W]),
      .err_o      (err_w)
    );

    assign errCntOut[g*ERR_W +: ERR_W] = err_w;
    // counter value after this cycle's update is still zero
    assign chan_clean[g] = (err_w == '0) & ~chan_err_ev[g];
  end

  always_comb begin
    state_d    = state_q;
    meas_cnt_d = meas_cnt_q;
    num_d      = num_q;
    min_d      = min_q;
    max_d      = max_q;
    pass_d     = pass_q;
    unique case (state_q)
      IDLE: begin
        if (startIn) begin
          state_d    = ARM;
          num_d      = (numMeasIn == '0) ? 16'd1 : numMeasIn;
          min_d      = minSkewIn;
          max_d      = maxSkewIn;
          meas_cnt_d = '0;
          pass_d     = 1'b0;
        end
      end
      ARM:      state_d = WAIT_REF;
      WAIT_REF: if (ref_edge) state_d = MEAS;
      MEAS: begin
        if (win_end) begin
          meas_cnt_d = meas_cnt_q + 16'd1;
          if (meas_cnt_d == num_q) begin
            state_d = DONE;
            pass_d  = &chan_clean;
          end else begin
            state_d = WAIT_REF;
          end
        end
      end
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkIn or negedge rstBIn) begin
    if (!rstBIn) begin
      state_q    <= IDLE;
      meas_cnt_q <= '0;
      num_q      <= '0;
      min_q      <= '0;
      max_q      <= '0;
      pass_q     <= 1'b0;
      ref_sync_q <= '0;
      ref_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      meas_cnt_q <= meas_cnt_d;
      num_q      <= num_d;
      min_q      <= min_d;
      max_q      <= max_d;
      pass_q     <= pass_d;
      ref_sync_q[0] <= refIn;
      for (int i = 1; i < SYNC_STAGES; i++)
        ref_sync_q[i] <= ref_sync_q[i-1];
      ref_prev_q <= ref_sync_q[SYNC_STAGES-1];
    end
  end

  assign busyOut = (state_q == ARM) | (state_q == WAIT_REF) | meas;
  assign doneOut = (state_q == DONE);
  assign passOut = pass_q;

`ifdef SKEW_MON_IRQ_EN
  logic irq_q, irq_d;

  always_comb begin
    irq_d = irq_q | (|chan_err_ev);
    if (start_ok) irq_d = 1'b0;
  end

  always_ff @(posedge clkIn or negedge rstBIn) begin
    if (!rstBIn) irq_q <= 1'b0;
    else         irq_q <= irq_d;
  end

  assign irqOut = irq_q;
`endif

endmodule
